// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and defaults.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer of fetched entries: allocated in request order,
// filled in response order, popped in program order.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_data,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   unfilled
);

  fetch_entry_t entries [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic [AW-1:0] fill_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] unfilled_q;
  logic          do_fill;
  logic          do_pop;

  // A response with nothing waiting for it is dropped rather than corrupting an entry.
  assign do_fill  = fill && (unfilled_q != '0);
  assign do_pop   = pop && entries[head_ptr].filled;
  assign head     = entries[head_ptr];
  assign count    = count_q;
  assign unfilled = unfilled_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].filled <= 1'b0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      // Freed slots must lose their filled flag or the head could wrap onto stale data.
      if (do_pop) begin
        entries[head_ptr].filled <= 1'b0;
        head_ptr <= head_ptr + AW'(1);
      end
      if (alloc) begin
        entries[tail_ptr].pc     <= alloc_pc;
        entries[tail_ptr].filled <= 1'b0;
        tail_ptr <= tail_ptr + AW'(1);
      end
      if (do_fill) begin
        entries[fill_ptr].instr  <= fill_data;
        entries[fill_ptr].filled <= 1'b1;
        fill_ptr <= fill_ptr + AW'(1);
      end
      count_q    <= count_q + CW'(alloc) - CW'(do_pop);
      unfilled_q <= unfilled_q + CW'(alloc) - CW'(do_fill);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, memory requests, redirect handling.
// XLEN must match riscv_pkg::XLEN since buffer entries use the package struct.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   unfilled;
  fetch_entry_t    head;
  logic            alloc;
  logic            fill;
  logic            pop;
  logic            full;

  assign full      = (count == CW'(DEPTH));
  assign imem_req  = rst_n && !redirect_valid && !full && (drop_cnt == '0);
  assign imem_addr = pc_q;
  assign alloc     = imem_req && imem_gnt;
  assign fill      = imem_rvalid && !redirect_valid && (drop_cnt == '0);

  assign if_valid    = head.filled;
  assign pop         = if_valid && if_ready && !redirect_valid;
  assign if_instr    = if_valid ? head.instr : '0;
  assign if_pc       = if_valid ? head.pc : '0;
  assign if_pc_plus4 = if_valid ? head.pc + XLEN'(4) : '0;

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .alloc     (alloc),
    .alloc_pc  (pc_q),
    .fill      (fill),
    .fill_data (imem_rdata),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .unfilled  (unfilled)
  );

  // Outstanding = already-dropping + unfilled; a response landing this cycle is one of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc_q     <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= drop_cnt + unfilled - CW'(imem_rvalid);
    end else begin
      if (alloc) pc_q <= pc_q + XLEN'(4);
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((drop_cnt != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] plus4_2;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(1'b1), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(valid2), .if_ready(1'b1), .if_instr(instr2),
    .if_pc(pc2), .if_pc_plus4(plus4_2)
  );

  // Memory model: in-order responses lat cycles after the grant; cleared by reset.
  int          lat = 1;
  int          cyc = 0;
  logic        rst_seen = 1'b0;
  logic        hs = 1'b0;
  logic [31:0] hs_addr = '0;
  logic        hs2 = 1'b0;
  logic [31:0] hs2_addr = '0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] gnt_log[$];
  logic [31:0] pop_log[$];

  always @(negedge clk) begin
    rst_seen = rst_n;
    hs       = rst_n && imem_req && imem_gnt;
    hs_addr  = imem_addr;
    hs2      = rst_n && req2;
    hs2_addr = addr2;
    if (hs) gnt_log.push_back(imem_addr);
    if (rst_n && if_valid && if_ready && !redirect_valid) pop_log.push_back(if_pc);
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    rvalid2 = hs2;
    rdata2  = hs2_addr ^ KEY;
    if (!rst_seen) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (hs) begin
        pend_addr.push_back(hs_addr);
        pend_due.push_back(cyc + lat - 1);
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr[0] ^ KEY;
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic gnt,
                               input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n          = rst;
    if_ready       = rdy;
    imem_gnt       = gnt;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic doReset(input string tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    gnt_log.delete();
    pop_log.delete();
    checkOutput({tag, "_rst_req"},   32'(imem_req), 32'd0);
    checkOutput({tag, "_rst_valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, "_rst_addr"},  imem_addr, 32'h0);
    checkOutput({tag, "_rst_pc"},    if_pc, 32'h0);
    checkOutput({tag, "_rst_instr"}, if_instr, 32'h0);
    checkOutput({tag, "_rst_plus4"}, if_pc_plus4, 32'h0);
    checkOutput({tag, "_rst_addr2"}, addr2, 32'hFFFF_FFF8);
  endtask

  typedef struct {
    logic        restart;
    logic        ready;
    logic        gnt;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [21];

  initial begin
    logic found;

    // Test 1: single-cycle memory, ready high
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd4,   1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'd8,   1'b1, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd8,   1'b1, 32'd4};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd12,  1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'd16,  1'b1, 32'd8};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd16,  1'b1, 32'd12};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd20,  1'b0, 32'd0};
    // Test 4: redirect with rvalid and pop in the same cycle
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd4,   1'b0, 32'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h202, 1'b0, 32'd8,   1'b1, 32'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'd0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};
    // Test 5: grant withheld for four cycles
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd0,   1'b0, 32'd0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'd4,   1'b0, 32'd0};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'd8,   1'b1, 32'd0};

    lat = 1;
    for (int i = 0; i < 21; i++) begin
      if (vecs[i].restart) doReset($sformatf("v%0d", i));
      applyStimulus(1'b1, vecs[i].ready, vecs[i].gnt, vecs[i].redir, vecs[i].rpc);
      checkOutput($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].req));
      checkOutput($sformatf("v%0d_addr", i),  imem_addr, vecs[i].addr);
      checkOutput($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("v%0d_pc", i),    if_pc, vecs[i].pc);
      checkOutput($sformatf("v%0d_instr", i), if_instr, vecs[i].valid ? (vecs[i].pc ^ KEY) : 32'h0);
      checkOutput($sformatf("v%0d_plus4", i), if_pc_plus4, vecs[i].valid ? (vecs[i].pc + 32'd4) : 32'h0);
    end

    // Test 2: decode stalls for six cycles
    doReset("t2");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      if (i >= 2) begin
        checkOutput($sformatf("t2_c%0d_req", i),   32'(imem_req), 32'd0);
        checkOutput($sformatf("t2_c%0d_valid", i), 32'(if_valid), 32'd1);
        checkOutput($sformatf("t2_c%0d_pc", i),    if_pc, 32'h0);
        checkOutput($sformatf("t2_c%0d_instr", i), if_instr, KEY);
      end
    end
    checkOutput("t2_grants", gnt_log.size(), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_rel_pc0", if_pc, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_rel_pc4", if_pc, 32'h4);
    checkOutput("t2_rel_addr", imem_addr, 32'h8);
    checkOutput("t2_rel_req", 32'(imem_req), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t2_pops", pop_log.size(), 32'd2);
    checkOutput("t2_pop0", pop_log.size() >= 1 ? pop_log[0] : 32'hFFFF_FFFF, 32'h0);
    checkOutput("t2_pop1", pop_log.size() >= 2 ? pop_log[1] : 32'hFFFF_FFFF, 32'h4);
    checkOutput("t2_gnt3", gnt_log.size() >= 3 ? gnt_log[2] : 32'hFFFF_FFFF, 32'h8);

    // Test 3: redirect with two slow responses in flight
    lat = 3;
    doReset("t3");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
    checkOutput("t3_redir_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_drop1_req", 32'(imem_req), 32'd0);
    checkOutput("t3_drop1_valid", 32'(if_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_drop2_req", 32'(imem_req), 32'd0);
    checkOutput("t3_drop2_valid", 32'(if_valid), 32'd0);
    checkOutput("t3_grants", gnt_log.size(), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_resume_req", 32'(imem_req), 32'd1);
    checkOutput("t3_resume_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (if_valid) found = 1'b1;
    end
    checkOutput("t3_wait_valid", 32'(found), 32'd1);
    checkOutput("t3_first_pc", if_pc, 32'h100);
    checkOutput("t3_first_instr", if_instr, 32'h100 ^ KEY);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_pop0", pop_log.size() >= 1 ? pop_log[0] : 32'hFFFF_FFFF, 32'h100);

    // Test 6: reset PC near the top of the address space (second instance)
    lat = 1;
    doReset("t6");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_c0_addr", addr2, 32'hFFFF_FFF8);
    checkOutput("t6_c0_req", 32'(req2), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_c1_addr", addr2, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_c2_pc", pc2, 32'hFFFF_FFF8);
    checkOutput("t6_c2_plus4", plus4_2, 32'hFFFF_FFFC);
    checkOutput("t6_c2_instr", instr2, 32'hFFFF_FFF8 ^ KEY);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_c3_addr", addr2, 32'h0);
    checkOutput("t6_c3_req", 32'(req2), 32'd1);
    checkOutput("t6_c3_pc", pc2, 32'hFFFF_FFFC);
    checkOutput("t6_c3_plus4", plus4_2, 32'h0);

    // Test 7: reset with a full buffer
    doReset("t7");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t7_full_valid", 32'(if_valid), 32'd1);
    checkOutput("t7_full_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t7_rst_valid", 32'(if_valid), 32'd0);
    checkOutput("t7_rst_req", 32'(imem_req), 32'd0);
    checkOutput("t7_rst_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t7_restart_req", 32'(imem_req), 32'd1);
    checkOutput("t7_restart_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t7_first_valid", 32'(if_valid), 32'd1);
    checkOutput("t7_first_pc", if_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
